seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display, sitting directly downstream of the counter/stopwatch FSMs. It consumes four 4-bit glyph codes and drives the active-low DIGIT and DISPLAY pins. It adds tear-free frame-synchronous updates, per-digit blinking and a frame strobe. This replaces the ad-hoc scan loops inside each lab top-level.

## Interface
- SCAN_DIV, 100000: clk cycles per digit slot (≥2).
- BLINK_FRAMES, 64: full frames per blink half-period (≥1).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- code_in  in  16  four glyph codes; [3:0] is the rightmost digit, [15:12] the leftmost.
- load  in  1  one-cycle strobe; captures code_in into the pending register.
- blink_en  in  1  enables blinking.
- blink_mask  in  4  per-digit blink select; bit i corresponds to slot i.
- DIGIT  out  4  active-low anode select; slot 0 is 4'b1110 and slot 3 is 4'b0111.
- DISPLAY  out  7  active-low segments, {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- **Glyph map (code → DISPLAY):**
  - 0→100_0000, 1→111_1001, 2→010_0100, 3→011_0000, 4→001_1001.
  - 5→001_0010, 6→000_0010, 7→111_1000, 8→000_0000, 9→001_0000.
  - 10 P→000_1100, 11 UP→101_1100, 12 DOWN→110_0011, 13 dash→011_1111.
  - 14, 15 blank→111_1111.
- **Registers:**
  - div: 0..SCAN_DIV-1.
  - slot: 2 bits.
  - pending[15:0] and active[15:0].
  - bcnt: 0..BLINK_FRAMES-1.
  - phase: 1 bit.
  - DIGIT, DISPLAY, frame_done: all registered.
- **Tick:** asserted when div == SCAN_DIV-1. On a tick, div returns to 0; otherwise div increments.
- **Slot advance:** on a tick, slot goes to slot+1, wrapping 3→0.
- **Outputs on a tick:**
  - DIGIT takes the one-cold code of the new slot.
  - DISPLAY takes glyph(active code of the new slot), or 7'h7F if that digit is blanked.
  - DIGIT and DISPLAY always change on the same edge.
- **Pending capture:** load writes code_in into pending on the same edge. Repeated loads overwrite; the last one wins.
- **Frame wrap** (a tick with slot==3):
  - active takes pending, or code_in directly if load is asserted in that same cycle.
  - The new slot-0 DISPLAY is decoded from the new active value.
  - frame_done is 1 for that one cycle.
- **Blanking rule:** a digit is blanked when blink_en && phase && blink_mask[slot].
- **Blink counter:**
  - At each frame wrap with blink_en=1: if bcnt == BLINK_FRAMES-1, clear bcnt and toggle phase; otherwise increment bcnt.
  - With blink_en=0: bcnt and phase are held at 0.
- **Control-input timing:** blink_en and blink_mask changes become visible only at the next slot advance. DISPLAY is never updated between ticks.
- **Reset** (async, any time, mid-frame included):
  - div=0, slot=0, pending=active=16'hFFFF (all blank).
  - bcnt=0, phase=0.
  - DIGIT=4'b1110, DISPLAY=7'h7F, frame_done=0.

## Timing
- **Slot period:** exactly SCAN_DIV cycles.
- **Frame period:** 4·SCAN_DIV cycles.
- **First tick after reset release:** SCAN_DIV cycles later. That edge selects slot 1.
- **Load latency:**
  - Load → visible on the next frame wrap, at most 4·SCAN_DIV cycles.
  - The current frame always completes with the old active value, so no mixed frames.
- **Blink half-period:** BLINK_FRAMES frames. The first blanked frame starts BLINK_FRAMES frames after blink_en rises.
- **Reset release:** synchronous operation resumes on the first clk edge after rst rises.

## Structure
- **Package seg7_pkg:**
  - Glyph code constants: GLYPH_P=10, GLYPH_UP=11, GLYPH_DOWN=12, GLYPH_DASH=13, GLYPH_BLANK=15.
  - SEG_OFF=7'h7F.
  - Slot-to-DIGIT one-cold constants.
- **Sub-module seg7_glyph:**
  - Purely combinational 4→7 decoder implementing the glyph map.
  - Instantiated once; the driver registers its output.
- **Reuse:** counter-FSM tops instantiate seg7_scan_driver and pulse load when their digit registers change.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2.
1. **Reset:** hold rst=0 → DIGIT=1110, DISPLAY=7F, frame_done=0. Release → DIGIT steps 1101, 1011, 0111, 1110 every 4 cycles, DISPLAY stays 7F throughout.
2. **Load:** load code_in=16'h0123 mid-frame → the current frame stays blank. After the wrap (frame_done=1), slot DISPLAYs read 011_0000, 010_0100, 111_1001, 100_0000.
3. **Special glyphs:** load 16'hBCDE → slots show blank(14), dash 011_1111, DOWN 110_0011, UP 101_1100.
4. **Load on wrap:** load 16'h9999 in the exact wrap cycle → the new frame shows 9 on all digits immediately. Load 16'h1111 then 16'h2222 within one frame → only 2 is ever shown.
5. **Blink:** active 16'h8888, blink_en=1, blink_mask=4'b0001 → slot 0 is 7F during frames 3-4 after enable and shows 000_0000 during frames 1-2 and 5-6; other slots are never blanked. Dropping blink_en → slot 0 is visible again at the next slot advance.
6. **Reset mid-operation:** assert rst during slot 2 with blinking active → all reset values appear immediately and the pending load is discarded.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph codes, segment and anode patterns.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package seg7_pkg;

    localparam logic [3:0] GLYPH_P     = 4'd10;
    localparam logic [3:0] GLYPH_UP    = 4'd11;
    localparam logic [3:0] GLYPH_DOWN  = 4'd12;
    localparam logic [3:0] GLYPH_DASH  = 4'd13;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    // Active-low segments: all ones turns every segment off.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low anode selects, one cold bit per slot.
    localparam logic [3:0] DIGIT_SLOT0 = 4'b1110;
    localparam logic [3:0] DIGIT_SLOT1 = 4'b1101;
    localparam logic [3:0] DIGIT_SLOT2 = 4'b1011;
    localparam logic [3:0] DIGIT_SLOT3 = 4'b0111;

    // Four blank glyphs, the power-up content of both code registers.
    localparam logic [15:0] CODES_BLANK = {4{GLYPH_BLANK}};

    function automatic logic [3:0] slot_digit(input logic [1:0] slot);
        logic [3:0] d;
        case (slot)
            2'd0:    d = DIGIT_SLOT0;
            2'd1:    d = DIGIT_SLOT1;
            2'd2:    d = DIGIT_SLOT2;
            default: d = DIGIT_SLOT3;
        endcase
        return d;
    endfunction

    // Slot 0 is the rightmost nibble.
    function automatic logic [3:0] slot_code(input logic [15:0] codes, input logic [1:0] slot);
        return codes[{slot, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Glyph decoder: 4-bit display code to active-low {g,f,e,d,c,b,a} segment pattern.
// Latency: purely combinational.
// Backpressure: none.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Table lookup; codes 14 and 15 both render as blank.
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:       seg = 7'b100_0000;
            4'd1:       seg = 7'b111_1001;
            4'd2:       seg = 7'b010_0100;
            4'd3:       seg = 7'b011_0000;
            4'd4:       seg = 7'b001_1001;
            4'd5:       seg = 7'b001_0010;
            4'd6:       seg = 7'b000_0010;
            4'd7:       seg = 7'b111_1000;
            4'd8:       seg = 7'b000_0000;
            4'd9:       seg = 7'b001_0000;
            GLYPH_P:    seg = 7'b000_1100;
            GLYPH_UP:   seg = 7'b101_1100;
            GLYPH_DOWN: seg = 7'b110_0011;
            GLYPH_DASH: seg = 7'b011_1111;
            default:    seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-seg driver with frame-synchronous code update, per-digit blink and frame strobe.
// Latency: outputs change only on slot ticks (every SCAN_DIV cycles); a load shows from the next frame wrap.
// Backpressure: none; load is always accepted, the last load before a wrap wins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] code_in,
    input  logic        load,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  DIGIT,
    output logic [6:0]  DISPLAY,
    output logic        frame_done
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]  div;
    logic [1:0]        slot;
    logic [1:0]        slot_nxt;
    logic [15:0]       pending;
    logic [15:0]       active;
    logic [15:0]       active_nxt;
    logic [BCNT_W-1:0] bcnt;
    logic              phase;
    logic              tick;
    logic              wrap;
    logic              blank;
    logic [3:0]        code_sel;
    logic [6:0]        seg;

    // Tick/wrap detection and selection of the code for the slot about to be driven.
    // Decoding from active_nxt lets a wrap show the freshly latched frame on slot 0 at once.
    always_comb begin
        tick       = (div == DIV_LAST);
        slot_nxt   = slot + 2'd1;
        wrap       = tick && (slot == 2'd3);
        active_nxt = active;
        if (wrap) begin
            active_nxt = load ? code_in : pending;
        end
        code_sel   = slot_code(active_nxt, slot_nxt);
        blank      = blink_en && phase && blink_mask[slot_nxt];
    end

    seg7_glyph u_glyph (
        .code (code_sel),
        .seg  (seg)
    );

    // Slot timer: divider plus the slot index it advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div  <= '0;
            slot <= 2'd0;
        end else if (tick) begin
            div  <= '0;
            slot <= slot_nxt;
        end else begin
            div  <= div + DIV_W'(1);
        end
    end

    // Double-buffered codes: pending collects loads, active swaps only at a frame wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= CODES_BLANK;
            active  <= CODES_BLANK;
        end else begin
            if (load) begin
                pending <= code_in;
            end
            active <= active_nxt;
        end
    end

    // Registered pin drive: anode and segments move together on every tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DIGIT      <= DIGIT_SLOT0;
            DISPLAY    <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                DIGIT   <= slot_digit(slot_nxt);
                DISPLAY <= blank ? SEG_OFF : seg;
            end
        end
    end

    // Blink timebase: counts frames while enabled, flips phase every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (!blink_en) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (bcnt == BCNT_LAST) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt  <= bcnt + BCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2.
// Every cycle is compared against a cycle-count based reference model; directed sequences add fixed expectations.
// Stimulus: glyph table, load timing corners, blink schedule, async reset, then randomized traffic.
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] code_in;
    logic        load;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .load       (load),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [16];

    int tests = 0;
    int fails = 0;

    // Reference model state: edges since reset release, enabled frame wraps since blink enable.
    int          n;
    int          bl;
    logic [15:0] m_pend;
    logic [15:0] m_act;
    logic [3:0]  m_dig;
    logic [6:0]  m_disp;
    logic        m_fd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        bl     = 0;
        m_pend = 16'hFFFF;
        m_act  = 16'hFFFF;
        m_dig  = 4'b1110;
        m_disp = 7'h7F;
        m_fd   = 1'b0;
    endtask

    // Slot k of the display runs from edge k*SD; a frame wraps every 4*SD edges.
    task automatic model_step(input logic l, input logic [15:0] c, input logic be, input logic [3:0] bm);
        int   s;
        bit   tk;
        bit   wr;
        bit   blk;
        logic [3:0] onehot;
        n++;
        tk  = (n % SD) == 0;
        s   = (n / SD) % 4;
        wr  = tk && (s == 0);
        blk = be && (((bl / BF) % 2) == 1) && bm[s];
        if (wr) m_act = l ? c : m_pend;
        if (l) m_pend = c;
        if (tk) begin
            onehot = 4'b0001 << s;
            m_dig  = ~onehot;
            m_disp = blk ? 7'h7F : vecs[m_act[4*s +: 4]].seg;
        end
        m_fd = wr;
        if (!be) bl = 0;
        else if (wr) bl++;
    endtask

    // One clock: drive at negedge, compare #1 after posedge, return at next negedge.
    task automatic cyc(input logic l, input logic [15:0] c);
        logic       be;
        logic [3:0] bm;
        load    = l;
        code_in = c;
        be      = blink_en;
        bm      = blink_mask;
        @(posedge clk);
        model_step(l, c, be, bm);
        #1;
        check("digit", DIGIT, m_dig);
        check("display", DISPLAY, m_disp);
        check("frame_done", frame_done, m_fd);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_digit", DIGIT, 4'b1110);
        check("rst_display", DISPLAY, 7'h7F);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_wrap();
        for (int k = 0; k < 4 * SD + 1; k++) begin
            cyc(1'b0, 16'h0000);
            if (m_fd) break;
        end
    endtask

    task automatic next_tick();
        for (int k = 0; k < SD + 1; k++) begin
            cyc(1'b0, 16'h0000);
            if ((n % SD) == 0) break;
        end
    endtask

    // Segments of one complete frame, starting from the next wrap; index = slot.
    task automatic frame_segs(output logic [3:0][6:0] s);
        wait_wrap();
        s[0] = DISPLAY;
        for (int i = 1; i < 4; i++) begin
            next_tick();
            s[i] = DISPLAY;
        end
    endtask

    task automatic run_to_before_wrap();
        for (int k = 0; k < 4 * SD + 1; k++) begin
            if (((n + 1) % (4 * SD)) == 0) break;
            cyc(1'b0, 16'h0000);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][6:0] s;
        logic [3:0] scan_exp [4];
        logic [6:0] exp0;

        vecs[0]  = '{4'd0,  7'b100_0000};
        vecs[1]  = '{4'd1,  7'b111_1001};
        vecs[2]  = '{4'd2,  7'b010_0100};
        vecs[3]  = '{4'd3,  7'b011_0000};
        vecs[4]  = '{4'd4,  7'b001_1001};
        vecs[5]  = '{4'd5,  7'b001_0010};
        vecs[6]  = '{4'd6,  7'b000_0010};
        vecs[7]  = '{4'd7,  7'b111_1000};
        vecs[8]  = '{4'd8,  7'b000_0000};
        vecs[9]  = '{4'd9,  7'b001_0000};
        vecs[10] = '{4'd10, 7'b000_1100};
        vecs[11] = '{4'd11, 7'b101_1100};
        vecs[12] = '{4'd12, 7'b110_0011};
        vecs[13] = '{4'd13, 7'b011_1111};
        vecs[14] = '{4'd14, 7'b111_1111};
        vecs[15] = '{4'd15, 7'b111_1111};

        scan_exp[0] = 4'b1101;
        scan_exp[1] = 4'b1011;
        scan_exp[2] = 4'b0111;
        scan_exp[3] = 4'b1110;

        load       = 1'b0;
        code_in    = 16'h0000;
        blink_en   = 1'b0;
        blink_mask = 4'b0000;

        // Reset values, then blank scan through one full frame.
        do_reset();
        for (int k = 1; k <= 4 * SD; k++) begin
            cyc(1'b0, 16'h0000);
            if ((k % SD) == 0) check("scan_digit", DIGIT, scan_exp[k / SD - 1]);
            check("scan_blank", DISPLAY, 7'h7F);
        end
        check("scan_frame_done", frame_done, 1'b1);

        // Mid-frame load: old (blank) frame completes, then the new digits appear.
        cyc(1'b0, 16'h0000);
        cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h0123);
        for (int k = 0; k < 4 * SD; k++) begin
            if (((n + 1) % (4 * SD)) == 0) break;
            cyc(1'b0, 16'h0000);
            check("old_frame_blank", DISPLAY, 7'h7F);
        end
        frame_segs(s);
        check("load_0123", s, {7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000});

        // Special glyphs.
        cyc(1'b1, 16'hBCDE);
        frame_segs(s);
        check("special_bcde", s, {7'b101_1100, 7'b110_0011, 7'b011_1111, 7'h7F});

        // Full glyph table, each code on all four digits.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, {4{vecs[i].code}});
            frame_segs(s);
            check("glyph_table", s, {4{vecs[i].seg}});
        end

        // Load in the exact wrap cycle takes effect immediately.
        run_to_before_wrap();
        cyc(1'b1, 16'h9999);
        check("wrap_load_fd", frame_done, 1'b1);
        check("wrap_load_seg", DISPLAY, 7'b001_0000);
        for (int i = 1; i < 4; i++) begin
            next_tick();
            check("wrap_load_rest", DISPLAY, 7'b001_0000);
        end

        // Two loads within one frame: only the last is ever shown.
        cyc(1'b1, 16'h1111);
        cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h2222);
        frame_segs(s);
        check("last_load_wins", s, {4{7'b010_0100}});

        // Blink on slot 0: frames 3, 4 and 7 after enable are blanked.
        cyc(1'b1, 16'h8888);
        wait_wrap();
        cyc(1'b0, 16'h0000);
        cyc(1'b0, 16'h0000);
        blink_en   = 1'b1;
        blink_mask = 4'b0001;
        for (int f = 1; f <= 7; f++) begin
            frame_segs(s);
            exp0 = (f == 3 || f == 4 || f == 7) ? 7'h7F : 7'b000_0000;
            check("blink_slot0", s[0], exp0);
            check("blink_others", {s[3], s[2], s[1]}, {3{7'b000_0000}});
        end
        blink_en = 1'b0;
        frame_segs(s);
        check("blink_off_visible", s[0], 7'b000_0000);

        // Async reset in slot 2 with blinking active and a load pending.
        blink_en   = 1'b1;
        blink_mask = 4'hF;
        for (int k = 0; k < 4 * SD + 1; k++) begin
            if (((n / SD) % 4) == 2 && (n % SD) == 1) break;
            cyc(1'b0, 16'h0000);
        end
        cyc(1'b1, 16'h4567);
        do_reset();
        frame_segs(s);
        check("post_reset_blank", s, {4{7'h7F}});

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom);
            cyc($urandom_range(0, 7) == 0, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
